// File: rtl/hud_digit_writer.sv
// Sequential double-dabble converter that writes the decimal digits of a value into HUD slots,
// one per cycle, only while vblank is high.
module hud_digit_writer #(
  parameter int unsigned NUM_DIGITS = 13,
  parameter int unsigned VALUE_W    = 44,
  parameter bit          LEAD_BLANK = 1'b1,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  input  logic               vblank,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic               wr_en,
  output logic [3:0]         wr_idx,
  output logic [3:0]         wr_digit
);

  localparam int unsigned BcdW = (NUM_DIGITS + 1) * 4;
  localparam int unsigned CntW = $clog2(VALUE_W);

  typedef enum logic [2:0] {StIdle, StConvert, StWaitBlank, StWrite, StFinish} state_e;

  state_e               state_q, state_d;
  logic [VALUE_W-1:0]   shift_q, shift_d;
  logic [BcdW-1:0]      bcd_q, bcd_d, bcd_adj, bcd_step;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           slot_q, slot_d;
  logic                 pend_q, pend_d;
  logic [VALUE_W-1:0]   pend_val_q, pend_val_d;
  logic                 busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic                 wr_en_q, wr_en_d;
  logic [3:0]           wr_idx_q, wr_idx_d, wr_digit_q, wr_digit_d;
  logic [3:0]           disp [NUM_DIGITS];
  logic [3:0]           nib;
  logic                 seen;

  // One double-dabble step: add-3 correction, then shift {bcd, shift} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS) + 1; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BcdW-2:0], shift_q[VALUE_W-1]};
  end

  // Slot 0 is the most significant nibble; leading zeros blank unless overflowed.
  always_comb begin
    disp = '{default: 4'd0};
    nib  = 4'd0;
    seen = 1'b0;
    for (int s = 0; s < int'(NUM_DIGITS); s++) begin
      nib = bcd_q[(int'(NUM_DIGITS) - 1 - s)*4 +: 4];
      if (ovf_q) begin
        disp[s] = 4'd9;
      end else begin
        if (nib != 4'd0) seen = 1'b1;
        disp[s] = (LEAD_BLANK && !seen && s != int'(NUM_DIGITS) - 1) ? BLANK_CODE : nib;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_digit_d = wr_digit_q;

    if (start && state_q != StIdle && state_q != StFinish) begin
      pend_d     = 1'b1;
      pend_val_d = value;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StConvert;
        end
      end
      StConvert: begin
        shift_d = shift_q << 1;
        bcd_d   = bcd_step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(VALUE_W - 1)) begin
          ovf_d   = |bcd_step[BcdW-1 -: 4];
          state_d = StWaitBlank;
        end
      end
      StWaitBlank: begin
        if (vblank) begin
          wr_en_d    = 1'b1;
          wr_idx_d   = 4'd0;
          wr_digit_d = disp[0];
          slot_d     = 4'd1;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (slot_q == 4'(NUM_DIGITS)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFinish;
        end else if (vblank) begin
          wr_en_d    = 1'b1;
          wr_idx_d   = slot_q;
          wr_digit_d = disp[slot_q];
          slot_d     = slot_q + 4'd1;
        end
      end
      StFinish: begin
        // A start on this cycle is newer than anything already pending.
        if (start || pend_q) begin
          shift_d = start ? value : pend_val_q;
          pend_d  = 1'b0;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StConvert;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      slot_q     <= 4'd0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= 4'd0;
      wr_digit_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_digit_q <= wr_digit_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign wr_en    = wr_en_q;
  assign wr_idx   = wr_idx_q;
  assign wr_digit = wr_digit_q;

endmodule

// File: tb/tb_hud_digit_writer.sv
// Directed bench for hud_digit_writer: vector table of values with expected digit rows, plus
// sequences for vblank gaps, queued requests and mid-write reset.
module tb_hud_digit_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [43:0] value = '0;
  logic        vblank = 1'b1;
  logic        busy, done, ovf, wr_en;
  logic [3:0]  wr_idx, wr_digit;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hud_digit_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .vblank   (vblank),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_digit (wr_digit)
  );

  typedef struct {
    logic [43:0] val;
    logic [51:0] digits;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Issue one start with vblank high and collect the pass up to done.
  task automatic run_value(input logic [43:0] v, output int first_wr, output int done_cyc,
                           output int nstrobe, output logic [51:0] digits, output logic busy1,
                           output logic ovf1, output int order_err);
    first_wr = -1; done_cyc = -1; nstrobe = 0; digits = '0; busy1 = 1'b0; ovf1 = 1'b1;
    order_err = 0;
    @(negedge clk);
    start = 1'b1;
    value = v;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        busy1 = busy;
        ovf1  = ovf;
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = n;
        if (int'(wr_idx) != nstrobe) order_err++;
        if (int'(wr_idx) < 13) digits[(12 - int'(wr_idx))*4 +: 4] = wr_digit;
        nstrobe++;
      end
      if (done) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  initial begin
    vec_t        vecs [8];
    int          fw, dc, ns, oe, cnt, hold_bad, hold_cnt, passes, d1, d2, busy_after;
    logic [51:0] dg, dg2;
    logic        b1, o1, dropped;

    vecs[0] = '{44'd1234,           52'hFFFFFFFFF1234, 1'b0};
    vecs[1] = '{44'd0,              52'hFFFFFFFFFFFF0, 1'b0};
    vecs[2] = '{44'd9999999999999,  52'h9999999999999, 1'b0};
    vecs[3] = '{44'd10000000000000, 52'h9999999999999, 1'b1};
    vecs[4] = '{44'd7,              52'hFFFFFFFFFFFF7, 1'b0};
    vecs[5] = '{44'd105,            52'hFFFFFFFFFF105, 1'b0};
    vecs[6] = '{44'd1000000000000,  52'h1000000000000, 1'b0};
    vecs[7] = '{44'd17592186044415, 52'h9999999999999, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_idx_digit", 64'({wr_idx, wr_digit}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_value(vecs[i].val, fw, dc, ns, dg, b1, o1, oe);
      check($sformatf("v%0d_busy_next", i), 64'(b1), 64'd1);
      check($sformatf("v%0d_ovf_cleared", i), 64'(o1), 64'd0);
      check($sformatf("v%0d_first_wr_cycle", i), 64'(fw), 64'd46);
      check($sformatf("v%0d_done_cycle", i), 64'(dc), 64'd59);
      check($sformatf("v%0d_strobes", i), 64'(ns), 64'd13);
      check($sformatf("v%0d_order", i), 64'(oe), 64'd0);
      check($sformatf("v%0d_digits", i), 64'(dg), 64'(vecs[i].digits));
      check($sformatf("v%0d_ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
    end

    // vblank low at conversion end, then a gap after slot 5.
    vblank = 1'b0;
    @(negedge clk);
    start = 1'b1;
    value = 44'd1234;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (wr_en) cnt++;
    end
    check("gap_no_wr_while_low", 64'(cnt), 64'd0);
    vblank = 1'b1;
    ns = 0; oe = 0; dg = '0; hold_bad = 0; hold_cnt = 0; dropped = 1'b0; dc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        if (wr_en || wr_idx != 4'd5) hold_bad++;
        hold_cnt--;
        if (hold_cnt == 0) vblank = 1'b1;
      end
      if (wr_en) begin
        if (int'(wr_idx) != ns) oe++;
        if (int'(wr_idx) < 13) dg[(12 - int'(wr_idx))*4 +: 4] = wr_digit;
        ns++;
        if (wr_idx == 4'd5 && !dropped) begin
          vblank   = 1'b0;
          dropped  = 1'b1;
          hold_cnt = 3;
        end
      end
      if (done) begin
        dc = n;
        break;
      end
    end
    check("gap_reached_idx5", 64'(dropped), 64'd1);
    check("gap_hold_idx5_no_wr", 64'(hold_bad), 64'd0);
    check("gap_strobes", 64'(ns), 64'd13);
    check("gap_order", 64'(oe), 64'd0);
    check("gap_digits", 64'(dg), 64'h000FFFFFFFFF1234);
    check("gap_done_seen", 64'(dc >= 0), 64'd1);

    // Queued requests: 42 runs, 77 is overwritten by 88, 88 follows with no idle cycle.
    @(negedge clk);
    start = 1'b1;
    value = 44'd42;
    passes = 0; d1 = -1; d2 = -1; busy_after = 0; dg = '0; dg2 = '0; cnt = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 5)  begin start = 1'b1; value = 44'd77; end
      if (n == 10) begin start = 1'b1; value = 44'd88; end
      if (d1 >= 0 && n == d1 + 1) busy_after = int'(busy);
      if (wr_en) begin
        if (passes == 0 && int'(wr_idx) < 13) dg[(12 - int'(wr_idx))*4 +: 4] = wr_digit;
        else if (passes == 1 && int'(wr_idx) < 13) dg2[(12 - int'(wr_idx))*4 +: 4] = wr_digit;
        else cnt++;
      end
      if (done) begin
        if (passes == 0) d1 = n;
        else if (passes == 1) d2 = n;
        passes++;
      end
    end
    check("pend_first_digits", 64'(dg), 64'h000FFFFFFFFFFF42);
    check("pend_first_done", 64'(d1), 64'd59);
    check("pend_no_idle_gap", 64'(busy_after), 64'd1);
    check("pend_second_digits", 64'(dg2), 64'h000FFFFFFFFFFF88);
    check("pend_second_done", 64'(d2), 64'd118);
    check("pend_only_two_passes", 64'(passes), 64'd2);
    check("pend_no_extra_strobes", 64'(cnt), 64'd0);

    // Reset while writing, after slot 3.
    @(negedge clk);
    start = 1'b1;
    value = 44'd1234;
    dropped = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en && wr_idx == 4'd3) begin
        reset   = 1'b1;
        dropped = 1'b1;
        break;
      end
    end
    check("rst_reached_idx3", 64'(dropped), 64'd1);
    @(negedge clk);
    check("rst_wr_en_low", 64'(wr_en), 64'd0);
    check("rst_busy_low", 64'(busy), 64'd0);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (wr_en || done) cnt++;
    end
    check("rst_no_more_strobes", 64'(cnt), 64'd0);
    run_value(44'd5, fw, dc, ns, dg, b1, o1, oe);
    check("rst_after_first_wr", 64'(fw), 64'd46);
    check("rst_after_done", 64'(dc), 64'd59);
    check("rst_after_strobes", 64'(ns), 64'd13);
    check("rst_after_order", 64'(oe), 64'd0);
    check("rst_after_digits", 64'(dg), 64'h000FFFFFFFFFFFF5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hud_digit_writer.md
Name: hud_digit_writer

Overview:
- Producer side of the HUD digit row: takes a binary value, such as a drum-hit score, and converts it to decimal with a sequential double-dabble.
- Writes the resulting digits one per cycle into the digit slots (slot index, digit code, write strobe) that the digit display latches.
- Writes happen only during vertical blanking, so the displayed row never tears mid-frame.
- Sits between game/score logic and the HUD digit display.

Parameters:
- NUM_DIGITS, 13, digit slots driven; slot 0 is leftmost and most significant.
- VALUE_W, 44, width of the binary input value.
- LEAD_BLANK, 1, when 1, leading zeros are written as the blank code.
- BLANK_CODE, 4'hF, digit code the display renders as empty.

Ports:
- clk  input  1  system (pixel) clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to display value
- value  input  VALUE_W  binary value, sampled when start is accepted
- vblank  input  1  high during vertical blanking
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle pulse after the last slot write
- ovf  output  1  value exceeded 10^NUM_DIGITS-1 on the last conversion; held until the next acceptance
- wr_en  output  1  slot write strobe
- wr_idx  output  4  slot index, 0..NUM_DIGITS-1
- wr_digit  output  4  digit 0..9 or BLANK_CODE

Behaviour:
- Reset, synchronous and active-high, applies on any cycle including mid-conversion or mid-write:
  - state IDLE;
  - busy, done, ovf, wr_en all 0;
  - wr_idx 0, wr_digit 0;
  - pending request cleared;
  - the write in progress is abandoned and no further strobes are issued.
- States: IDLE, CONVERT, WAIT_BLANK, WRITE, FINISH.
- IDLE:
  - start=1 latches value into the shift register and clears the BCD register (NUM_DIGITS+1 nibbles; the extra nibble detects overflow).
  - Clears ovf; next state CONVERT; busy=1 from the next cycle.
- CONVERT:
  - Exactly VALUE_W cycles.
  - Each cycle: every BCD nibble >= 5 gets +3, then {bcd,shift} shifts left 1.
  - Counter hits VALUE_W-1 → WAIT_BLANK.
  - On exit, ovf=1 if the top nibble is nonzero; in that case all NUM_DIGITS digits are forced to 9.
- WAIT_BLANK:
  - Stays until vblank=1, then goes to WRITE with slot counter 0.
  - If vblank is already high, WRITE begins on the next cycle.
- WRITE:
  - Each cycle with vblank=1: wr_en=1, wr_idx=slot, wr_digit=digit for that slot; slot increments.
  - If vblank=0: wr_en=0, slot holds, and writing resumes at the same slot when vblank returns. A frame never receives a write from a different value.
  - After slot NUM_DIGITS-1 is written → FINISH.
- FINISH:
  - One cycle: done=1; busy=0 on that same cycle.
  - Next state IDLE, or CONVERT directly if a request is pending.
- Leading-zero blanking (LEAD_BLANK=1):
  - Slots before the first nonzero digit get BLANK_CODE.
  - The least significant slot always shows a digit, so value 0 displays "0".
  - ovf forces all 9s, so nothing is blanked.
- start while busy:
  - The request is not dropped. value is captured into a single pending register and the newest request wins.
  - The pending request is serviced right after FINISH.
  - start on the FINISH cycle counts as pending.
- Outputs wr_en, wr_idx, wr_digit, busy, done are registered.
- Latency with vblank already high: start at cycle 0 → first wr_en at cycle VALUE_W+2 → done at cycle VALUE_W+NUM_DIGITS+2.
- wr_idx and wr_digit hold their last values when wr_en=0.

Test Plan:
- Reset then start with value=1234, vblank=1:
  - busy next cycle; 13 consecutive wr_en strobes, idx 0..12;
  - idx 0..8 = 4'hF, idx 9..12 = 1,2,3,4;
  - done one cycle after idx 12, at cycle 59; ovf=0.
- value=0 → idx 0..11 = 4'hF, idx 12 = 0.
- value=9999999999999 → all 13 digits 9, ovf=0. value=10000000000000 → all 9, ovf=1.
- vblank=0 at conversion end → no wr_en until vblank rises.
  - Drop vblank after idx 5: wr_en=0, wr_idx holds 5.
  - On return, writing resumes at idx 6; exactly 13 strobes total, no duplicates.
- start(42) then start(77) and start(88) while busy:
  - after the first done, a second pass displays 88 with no idle cycle between;
  - 77 is never written.
- Assert reset during WRITE after idx 3:
  - the next cycle has wr_en=0 and busy=0, and no further strobes follow;
  - a subsequent start(5) writes all 13 slots cleanly.
